// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter:
// FSM state encodings, default timing, mouse command bytes and the frame builder.
package ps2_host_tx_pkg;

   // System clock frequency the default timings below assume (documentation only).
   localparam int unsigned CLK_HZ = 50_000_000;

   // 100 us clock-low inhibit at 50 MHz before the start bit is presented.
   localparam int unsigned DEF_INHIBIT_CYCLES = 5000;

   // 20 ms watchdog from clock release to the bus returning idle.
   localparam int unsigned DEF_TIMEOUT_CYCLES = 1_000_000;

   // Commonly used mouse commands.
   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;

   // Bits shifted out after the start bit: 8 data, parity, stop.
   localparam int unsigned FRAME_BITS = 10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } tx_state_e;

   // Serial frame, LSB shifted first: data[7:0], odd parity, stop (1 = released).
   function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
      return {1'b1, ~^data, data};
   endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Purpose: 2-FF synchronizers for PS2_CLK/PS2_DAT plus a registered clock falling-edge pulse.
// Latency: sync_clk_o/sync_dat_o 2 cycles from the pin, fall_o 3 cycles from the pin.
// Backpressure: none; free-running, one pulse per observed falling edge.
module ps2_host_tx_line_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic ps2_clk_i,
   input  logic ps2_dat_i,
   output logic sync_clk_o,
   output logic sync_dat_o,
   output logic fall_o
);

   logic [1:0] clk_ff_q;
   logic [1:0] dat_ff_q;
   logic       clk_prev_q;
   logic       fall_q;

   // Synchronize both lines and register the falling edge of the synchronized clock.
   // Reset to the idle-high line level so leaving reset never fakes an edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_ff_q   <= 2'b11;
         dat_ff_q   <= 2'b11;
         clk_prev_q <= 1'b1;
         fall_q     <= 1'b0;
      end else begin
         clk_ff_q   <= {clk_ff_q[0], ps2_clk_i};
         dat_ff_q   <= {dat_ff_q[0], ps2_dat_i};
         clk_prev_q <= clk_ff_q[1];
         fall_q     <= clk_prev_q & ~clk_ff_q[1];
      end
   end

   assign sync_clk_o = clk_ff_q[1];
   assign sync_dat_o = dat_ff_q[1];
   assign fall_o     = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Purpose: PS/2 host-to-device transmitter; sends one command byte to the mouse over open-collector lines.
// Latency: INHIBIT_CYCLES of clock inhibit, then device-paced (bit driven 4 cycles after each pin fall).
// Backpressure: send_i accepted only while idle (busy_o low); requests while busy are dropped, not queued.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   // Must be at least 2: the RELEASE cycle is the last of the clock-low window.
   parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       send_i,
   input  logic [7:0] command_i,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe_o,
   output logic       ps2_dat_oe_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o
);

   localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

   // Inhibit counter counts clock-low cycles starting at 1 in the first INHIBIT
   // cycle, so INHIBIT plus the RELEASE cycle hold the clock low INHIBIT_CYCLES in total.
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
   // Watchdog is 0 in the RELEASE cycle; the timeout takes effect TIMEOUT_CYCLES later.
   localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);

   tx_state_e             state_q;
   logic [FRAME_BITS-1:0] shift_q;
   logic [3:0]            bit_idx_q;
   logic [IW-1:0]         inh_q;
   logic [WW-1:0]         wd_q;
   logic                  ack_ok_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  error_q;
   logic                  clk_oe_q;
   logic                  dat_oe_q;

   logic                  sync_clk;
   logic                  sync_dat;
   logic                  fall;
   logic [FRAME_BITS-1:0] frame_d;
   logic                  wd_run;
   logic                  wd_hit;

   ps2_host_tx_line_sync u_line_sync (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_dat_i  (ps2_dat_i),
      .sync_clk_o (sync_clk),
      .sync_dat_o (sync_dat),
      .fall_o     (fall)
   );

   // Frame to load on accept and watchdog activity: it runs from RELEASE until back in IDLE.
   always_comb begin
      frame_d = build_frame(command_i);
      wd_run  = (state_q != ST_IDLE) && (state_q != ST_INHIBIT);
      wd_hit  = wd_run && (wd_q == WD_LAST);
   end

   // Transmit FSM with registered line enables and status pulses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         inh_q     <= '0;
         wd_q      <= '0;
         ack_ok_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         clk_oe_q  <= 1'b0;
         dat_oe_q  <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         if (wd_run) begin
            wd_q <= wd_q + WW'(1);
         end

         if (wd_hit) begin
            // Device stopped clocking or never let the bus go idle: give the lines back.
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            error_q  <= 1'b1;
            busy_q   <= 1'b0;
            wd_q     <= '0;
            state_q  <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (send_i) begin
                     shift_q  <= frame_d;
                     busy_q   <= 1'b1;
                     clk_oe_q <= 1'b1;
                     inh_q    <= IW'(1);
                     wd_q     <= '0;
                     state_q  <= ST_INHIBIT;
                  end
               end

               ST_INHIBIT: begin
                  // Falls here come from an aborted device packet and are ignored.
                  if (inh_q == INH_LAST) begin
                     dat_oe_q <= 1'b1;   // start bit, presented before the clock is released
                     state_q  <= ST_RELEASE;
                  end else begin
                     inh_q <= inh_q + IW'(1);
                  end
               end

               ST_RELEASE: begin
                  clk_oe_q  <= 1'b0;
                  bit_idx_q <= '0;
                  state_q   <= ST_SHIFT;
               end

               ST_SHIFT: begin
                  // Change data while the device holds the clock low; it samples on the rise.
                  if (fall) begin
                     dat_oe_q <= ~shift_q[0];
                     shift_q  <= {1'b1, shift_q[FRAME_BITS-1:1]};
                     if (bit_idx_q == BIT_LAST) begin
                        state_q <= ST_ACK;   // stop bit just released
                     end else begin
                        bit_idx_q <= bit_idx_q + 4'd1;
                     end
                  end
               end

               ST_ACK: begin
                  if (fall) begin
                     ack_ok_q <= ~sync_dat;
                     state_q  <= ST_WAIT_IDLE;
                  end
               end

               ST_WAIT_IDLE: begin
                  // Report only once the device has released both lines.
                  if (sync_clk && sync_dat) begin
                     done_q  <= ack_ok_q;
                     error_q <= ~ack_ok_q;
                     busy_q  <= 1'b0;
                     wd_q    <= '0;
                     state_q <= ST_IDLE;
                  end
               end

               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign ps2_clk_oe_o = clk_oe_q;
   assign ps2_dat_oe_o = dat_oe_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign error_o      = error_q;

endmodule
